// File: rtl/mips_pc_sequencer.sv
// Fetch-side PC sequencer: resolves jump/branch targets in decode with a single
// delay slot and holds a pending redirect while instruction memory stalls.
module mips_pc_sequencer #(
  parameter logic [31:0] ResetVector = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchReady,
  input  logic        controlValid,
  input  logic [1:0]  action,
  input  logic [1:0]  condition,
  input  logic [31:0] decodePc,
  input  logic [25:0] instrIndex,
  input  logic [15:0] immediate,
  input  logic [31:0] rsValue,
  input  logic [31:0] rtValue,
  output logic [31:0] pc,
  output logic        pcValid,
  output logic [31:0] linkAddr,
  output logic        misaligned
);

  localparam logic [1:0] ACT_INC    = 2'd0;
  localparam logic [1:0] ACT_JUMP   = 2'd1;
  localparam logic [1:0] ACT_JUMPR  = 2'd2;
  localparam logic [1:0] ACT_BRANCH = 2'd3;
  localparam logic [1:0] COND_EQ    = 2'd1;
  localparam logic [1:0] COND_NE    = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_pc_valid;
  logic [31:0] r_pending_target;
  logic [31:0] w_pending_next;
  logic        r_misaligned;
  logic        w_misaligned_next;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic        w_cond_true;
  logic        w_taken;

  assign w_base   = decodePc + 32'd4;
  assign linkAddr = decodePc + 32'd8;

  // Target selection and branch resolution for the decode instruction.
  always_comb begin
    w_target    = w_base;
    w_cond_true = 1'b0;
    w_taken     = 1'b0;
    case (condition)
      COND_EQ: w_cond_true = (rsValue == rtValue);
      COND_NE: w_cond_true = (rsValue != rtValue);
      default: w_cond_true = 1'b0;
    endcase
    case (action)
      ACT_JUMP: begin
        w_target = {w_base[31:28], instrIndex, 2'b00};
        w_taken  = controlValid;
      end
      ACT_JUMPR: begin
        w_target = {rsValue[31:2], 2'b00};
        w_taken  = controlValid;
      end
      ACT_BRANCH: begin
        w_target = w_base + {{14{immediate[15]}}, immediate, 2'b00};
        w_taken  = controlValid && w_cond_true;
      end
      ACT_INC: begin
        w_target = w_base;
        w_taken  = 1'b0;
      end
      default: begin
        w_target = w_base;
        w_taken  = 1'b0;
      end
    endcase
  end

  // Next-state logic: the delay slot at pc is always fetched before the target.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_pending_next    = r_pending_target;
    w_misaligned_next = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_taken) begin
          w_misaligned_next = (action == ACT_JUMPR) && (rsValue[1:0] != 2'b00);
          if (fetchReady) begin
            w_pc_next = w_target;
          end else begin
            w_pending_next = w_target;
            w_state_next   = ST_PENDING;
          end
        end else if (fetchReady && r_pc_valid) begin
          w_pc_next = r_pc + 32'd4;
        end else begin
          w_pc_next = r_pc;
        end
      end
      ST_PENDING: begin
        if (fetchReady) begin
          w_pc_next    = r_pending_target;
          w_state_next = ST_RUN;
        end else begin
          w_pc_next    = r_pc;
          w_state_next = ST_PENDING;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State and output registers; reset discards any pending redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= ST_RUN;
      r_pc             <= ResetVector;
      r_pc_valid       <= 1'b0;
      r_pending_target <= 32'h0000_0000;
      r_misaligned     <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_pc             <= w_pc_next;
      r_pc_valid       <= 1'b1;
      r_pending_target <= w_pending_next;
      r_misaligned     <= w_misaligned_next;
    end
  end

  assign pc         = r_pc;
  assign pcValid    = r_pc_valid;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed self-checking bench for mips_pc_sequencer.
module tb_mips_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchReady;
  logic        controlValid;
  logic [1:0]  action;
  logic [1:0]  condition;
  logic [31:0] decodePc;
  logic [25:0] instrIndex;
  logic [15:0] immediate;
  logic [31:0] rsValue;
  logic [31:0] rtValue;
  logic [31:0] pc;
  logic        pcValid;
  logic [31:0] linkAddr;
  logic        misaligned;

  int n_cmp  = 0;
  int n_fail = 0;

  mips_pc_sequencer #(.ResetVector(RV)) dut (
    .clock(clock), .reset(reset), .fetchReady(fetchReady),
    .controlValid(controlValid), .action(action), .condition(condition),
    .decodePc(decodePc), .instrIndex(instrIndex), .immediate(immediate),
    .rsValue(rsValue), .rtValue(rtValue), .pc(pc), .pcValid(pcValid),
    .linkAddr(linkAddr), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    controlValid = 1'b0;
    action       = 2'd0;
    condition    = 2'd0;
    decodePc     = 32'h0;
    instrIndex   = 26'h0;
    immediate    = 16'h0;
    rsValue      = 32'h0;
    rtValue      = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetchReady = 1'b0; idle();
    #3;
    n_cmp++; if (pc !== RV) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, RV); end
    n_cmp++; if (pcValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", pcValid); end
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
    tick(); tick();
    reset = 1'b0; fetchReady = 1'b1;
    tick();
    n_cmp++; if (pcValid !== 1'b1) begin n_fail++; $display("FAIL seq_valid got=%b exp=1", pcValid); end
    n_cmp++; if (pc !== 32'h0040_0000) begin n_fail++; $display("FAIL seq_pc0 got=%h exp=00400000", pc); end
    tick();
    n_cmp++; if (pc !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc1 got=%h exp=00400004", pc); end
    tick();
    n_cmp++; if (pc !== 32'h0040_0008) begin n_fail++; $display("FAIL seq_pc2 got=%h exp=00400008", pc); end
  endtask

  task automatic test_branch();
    controlValid = 1'b1; action = 2'd3; condition = 2'd1;
    decodePc = 32'h0040_0010; immediate = 16'hFFFC; rsValue = 32'd5; rtValue = 32'd5;
    #1;
    n_cmp++; if (linkAddr !== 32'h0040_0018) begin n_fail++; $display("FAIL link got=%h exp=00400018", linkAddr); end
    tick();
    n_cmp++; if (pc !== 32'h0040_0004) begin n_fail++; $display("FAIL beq_taken got=%h exp=00400004", pc); end
    rtValue = 32'd6;
    tick();
    n_cmp++; if (pc !== 32'h0040_0008) begin n_fail++; $display("FAIL beq_not_taken got=%h exp=00400008", pc); end
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL beq_mis got=%b exp=0", misaligned); end
  endtask

  task automatic test_jump();
    idle(); controlValid = 1'b1; action = 2'd1;
    decodePc = 32'h1000_0000; instrIndex = 26'h0000100;
    tick();
    n_cmp++; if (pc !== 32'h1000_0400) begin n_fail++; $display("FAIL jump got=%h exp=10000400", pc); end
    idle(); controlValid = 1'b1; action = 2'd2; rsValue = 32'h0040_0022;
    tick();
    n_cmp++; if (pc !== 32'h0040_0020) begin n_fail++; $display("FAIL jumpr got=%h exp=00400020", pc); end
    n_cmp++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL jumpr_mis got=%b exp=1", misaligned); end
    idle();
    tick();
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got=%b exp=0", misaligned); end
    n_cmp++; if (pc !== 32'h0040_0024) begin n_fail++; $display("FAIL after_jumpr got=%h exp=00400024", pc); end
  endtask

  task automatic test_back_to_back();
    idle(); fetchReady = 1'b0; controlValid = 1'b1; action = 2'd1;
    decodePc = 32'h0040_0020; instrIndex = 26'h0100040;
    tick();
    n_cmp++; if (pc !== 32'h0040_0024) begin n_fail++; $display("FAIL stall1 got=%h exp=00400024", pc); end
    idle(); controlValid = 1'b1; action = 2'd2; rsValue = 32'h1234_5677;
    tick();
    n_cmp++; if (pc !== 32'h0040_0024) begin n_fail++; $display("FAIL stall2 got=%h exp=00400024", pc); end
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL stall_mis got=%b exp=0", misaligned); end
    idle();
    tick();
    n_cmp++; if (pc !== 32'h0040_0024) begin n_fail++; $display("FAIL stall3 got=%h exp=00400024", pc); end
    fetchReady = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h0040_0100) begin n_fail++; $display("FAIL redirect got=%h exp=00400100", pc); end
    tick();
    n_cmp++; if (pc !== 32'h0040_0104) begin n_fail++; $display("FAIL post_redirect got=%h exp=00400104", pc); end
  endtask

  task automatic test_reset_pending();
    idle(); fetchReady = 1'b0; controlValid = 1'b1; action = 2'd1;
    decodePc = 32'h0040_0100; instrIndex = 26'h0000200;
    tick();
    n_cmp++; if (pc !== 32'h0040_0104) begin n_fail++; $display("FAIL pend_hold got=%h exp=00400104", pc); end
    idle();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (pc !== RV) begin n_fail++; $display("FAIL async_rst_pc got=%h exp=%h", pc, RV); end
    n_cmp++; if (pcValid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%b exp=0", pcValid); end
    tick();
    reset = 1'b0; fetchReady = 1'b1;
    tick();
    n_cmp++; if (pc !== RV || pcValid !== 1'b1) begin n_fail++; $display("FAIL rst_release got=%h/%b exp=%h/1", pc, pcValid, RV); end
    tick();
    n_cmp++; if (pc !== 32'h0040_0004) begin n_fail++; $display("FAIL no_stale got=%h exp=00400004", pc); end
  endtask

  task automatic test_edges();
    idle(); controlValid = 1'b1; action = 2'd3; condition = 2'd0;
    decodePc = 32'h0040_0000; immediate = 16'h0010; rsValue = 32'd7; rtValue = 32'd7;
    tick();
    n_cmp++; if (pc !== 32'h0040_0008) begin n_fail++; $display("FAIL cond_none got=%h exp=00400008", pc); end
    condition = 2'd3;
    tick();
    n_cmp++; if (pc !== 32'h0040_000C) begin n_fail++; $display("FAIL cond_rsvd got=%h exp=0040000c", pc); end
    action = 2'd0; condition = 2'd1;
    tick();
    n_cmp++; if (pc !== 32'h0040_0010) begin n_fail++; $display("FAIL inc_action got=%h exp=00400010", pc); end
    idle(); controlValid = 1'b1; action = 2'd2; rsValue = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL to_top got=%h exp=fffffffc", pc); end
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL aligned_mis got=%b exp=0", misaligned); end
    idle();
    tick();
    n_cmp++; if (pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap got=%h exp=00000000", pc); end
    controlValid = 1'b1; action = 2'd3; condition = 2'd2;
    decodePc = 32'h0; immediate = 16'h0010; rsValue = 32'd1; rtValue = 32'd2;
    tick();
    n_cmp++; if (pc !== 32'h0000_0044) begin n_fail++; $display("FAIL bne_taken got=%h exp=00000044", pc); end
    idle();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_back_to_back();
    test_reset_pending();
    test_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_pc_sequencer.md
# mips_pc_sequencer

Fetch-side program-counter sequencer for the pipelined MIPS core. It owns the architectural fetch PC and consumes the per-instruction PC control produced in decode: an action (Inc/Jump/JumpR/Branch) and a branch condition (None/EQ/NE). It resolves branch and jump targets in decode with MIPS single-delay-slot semantics. It holds a pending redirect across instruction-memory back-pressure.

## Interface
- `ResetVector`, default 32'h0040_0000: PC loaded on reset; must be word-aligned.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `fetchReady`  in  1  instruction memory accepts `pc` this cycle.
- `controlValid`  in  1  the decode instruction's control is valid and retires from decode this cycle; asserted at most once per instruction.
- `action`  in  2  0 Inc, 1 Jump, 2 JumpR, 3 Branch.
- `condition`  in  2  0 None, 1 EQ, 2 NE, 3 reserved (treated as None).
- `decodePc`  in  32  PC of the decode instruction.
- `instrIndex`  in  26  J-format target field.
- `immediate`  in  16  I-format branch offset, in words.
- `rsValue`, `rtValue`  in  32 each  forwarded operands.
- `pc`  out  32  fetch address.
- `pcValid`  out  1  `pc` is a real fetch request.
- `linkAddr`  out  32  `decodePc + 8`, combinational, for jal/jalr/bgezal writeback.
- `misaligned`  out  1  registered one-cycle pulse: a JumpR target had nonzero bits [1:0].

## Operation
- Sequential PC is `pc + 4` modulo 2^32. Base is `decodePc + 4`, called B.
- Jump target is `{B[31:28], instrIndex, 2'b00}`.
- JumpR target is `{rsValue[31:2], 2'b00}`. Low bits are forced to zero. `misaligned` pulses on the next edge when `rsValue[1:0] != 0`.
- Branch target is `B + (signext(immediate) << 2)`, 32-bit wrap-around.
- `taken` means `controlValid && (action==Jump || action==JumpR || (action==Branch && ((condition==EQ && rsValue==rtValue) || (condition==NE && rsValue!=rtValue))))`.
- Branch with condition None or reserved is never taken. Inc is never taken.
- Delay slot: when decode holds a control transfer at P, fetch presents P+4. That delay-slot fetch always completes. Only the PC after it is replaced by the target.
- FSM states:
  - Run:
    - `taken && fetchReady`: `pc <= target`, stay in Run.
    - `taken && !fetchReady`: `pendingTarget <= target`, `pc` holds, go to Pending.
    - not taken: `pc <= pc + 4` when `fetchReady && pcValid`, otherwise hold.
  - Pending:
    - `pc` holds the delay-slot address.
    - On `fetchReady`: `pc <= pendingTarget`, go to Run.
    - `controlValid` is ignored, and `misaligned` is not generated.
- After reset, `pcValid` rises at the first edge with `reset` low. `pc` stays `ResetVector` until the first accepted fetch.

## Timing
- Reset values: `pc = ResetVector`, `pcValid = 0`, `misaligned = 0`, state Run, `pendingTarget = 0`.
- `reset` takes effect immediately and asynchronously, at any time, including in Pending. A pending redirect is discarded.
- Redirect latency is one edge: the target appears on `pc` the cycle after the accepting cycle. If held in Pending, the target appears the cycle after `fetchReady` is seen.
- `pc` changes only on a rising edge. `linkAddr` is combinational.
- `fetchReady` is don't-care while `pcValid = 0`.
- Simultaneous `taken` and `fetchReady`: the target wins over `pc + 4`.
- Wrap: `pc = 32'hFFFF_FFFC` incrementing gives `0`.

## Test plan
- **Reset and sequential fetch.** Assert reset, release it, then hold `fetchReady=1` for 3 cycles. Required: `pcValid` rises after the first edge; `pc` goes 0x00400000 → 0x00400004 → 0x00400008.
- **Taken BEQ.**
  - Stimulus: `decodePc=0x00400010`, `immediate=16'hFFFC`, `rs=rt=5`, action Branch, condition EQ, `controlValid` and `fetchReady` both 1.
  - Required: next `pc = 0x00400004`.
  - Same stimulus with `rs=5, rt=6`: `pc` increments normally.
- **Jump and JumpR.**
  - Jump with `decodePc=0x10000000`, `instrIndex=26'h0000100`: next `pc = 0x10000400`.
  - JumpR with `rsValue=0x00400022`: next `pc = 0x00400020`, and `misaligned` pulses for 1 cycle.
- **Back-pressure.**
  - Stimulus: taken Jump to 0x00400100 with `fetchReady=0` for 3 cycles, then 1.
  - Required: `pc` holds the delay-slot address through the stall, then becomes 0x00400100. A `controlValid` pulse during the stall has no effect.
- **Reset mid-operation.** Assert `reset` while in Pending. Required: `pc = ResetVector` immediately; after release with `fetchReady=1`, there is no stale redirect.
- **Edge cases.** Branch with condition None and equal operands: not taken. Increment from 0xFFFFFFFC: `pc` becomes 0x00000000.
